display_scan_ctrl: RTL
======================

Name: display_scan_ctrl

Overview:
- PicoBlaze-attached controller that time-multiplexes an 8-digit common-anode seven-segment display.
- Holds one segment register per digit plus mask/control registers, written through the processor output port (port_id/write_strobe/out_port).
- Scans the digits with a programmable refresh period and an anti-ghosting blank interval.
- Provides registered read-back data for the processor in_port mux.

Parameters:
- NUM_DIGITS, 8: digits scanned; width of an; legal range 1..8.
- REFRESH_DIV, 100000: clk cycles per digit slot (1 kHz per digit at 100 MHz); must be ≥2.
- BLANK_CYCLES, 1000: cycles at the start of each slot with all anodes off; must be < REFRESH_DIV; 0 means no blank interval.
- BASE_PORT, 8'h10: port_id base; the block decodes port_id[7:4] == BASE_PORT[7:4].

Ports:
- clk, input, 1: system clock.
- reset_n, input, 1: asynchronous active-low reset.
- port_id, input, 8: PicoBlaze port address.
- write_strobe, input, 1: PicoBlaze output strobe.
- out_port, input, 8: PicoBlaze write data.
- rd_data, output, 8: registered read-back data, fed into the in_port mux.
- an, output, NUM_DIGITS: anode enables, active-low.
- seg, output, 8: segments {dp,g..a}, active-low.

Behaviour:
- Register map (offset = port_id[3:0]):
  - 0..NUM_DIGITS-1: DIGIT[i], raw active-low segment pattern.
  - 8: MASK; bit i = 1 enables digit i.
  - 9: CTRL; bit0 blank_all, bit1 lamp_test, other bits read 0.
  - 10: STATUS, read-only = {5'b0, idx[2:0]}.
  - Other offsets: writes ignored, reads return 8'h00. Offsets NUM_DIGITS..7 behave as unmapped.
- Write: on a rising clk edge with write_strobe=1 and a matching base, the addressed register takes out_port. Writes to STATUS or unmapped offsets have no effect.
- Read: rd_data <= decode(port_id) every clk, independent of strobes (1-cycle latency, matching the in_port timing). A non-matching base gives 8'h00. A read in the same cycle as a write to the same register returns the old value.
- Reset (async assert, outputs take reset values immediately):
  - DIGIT[*]=8'hFF, MASK=8'h01, CTRL=8'h00.
  - rd_data=8'h00, an=all 1s, seg=8'hFF.
  - idx=0, cnt=0, state=BLANK (or ON if BLANK_CYCLES=0).
- Scan counter: cnt counts 0..REFRESH_DIV-1 and wraps to 0. On wrap, idx increments; idx = NUM_DIGITS-1 wraps to 0.
- FSM (one per slot):
  - BLANK while cnt < BLANK_CYCLES: an = all 1s.
  - ON for the remaining cnt values.
  - BLANK -> ON when cnt == BLANK_CYCLES-1.
  - ON -> BLANK when cnt == REFRESH_DIV-1, unless BLANK_CYCLES=0, in which case the FSM stays in ON.
- Output register, computed each clk from next-state values:
  - ON and MASK[idx]=1: an = ~(1<<idx), seg = DIGIT[idx].
  - Otherwise: an = all 1s, seg = 8'hFF.
- Disabled digits still consume their slot; scan cadence never depends on MASK.
- blank_all=1 forces an = all 1s and seg = 8'hFF. It takes priority over lamp_test.
- lamp_test=1 (blank_all=0) in ON: an = ~(1<<idx) regardless of MASK, seg = 8'h00.
- A DIGIT[idx] write during ON appears on seg 2 cycles after the strobe edge: register update, then output register.
- Mid-scan reset returns to idx 0, slot start, with no partial-slot glitch: all anodes stay off through BLANK.
- No combinational path from any input to an/seg/rd_data.

Decomposition:
- Shared package: register offset constants (OFF_MASK=8, OFF_CTRL=9, OFF_STATUS=10), CTRL bit positions, the scan state enum {BLANK, ON}, and the reset values.
- One natural sub-module, scan_timer: cnt, idx, FSM, and slot-boundary pulses.
- Register file, decode, and output muxing stay in display_scan_ctrl.

Test Plan (REFRESH_DIV=8, BLANK_CYCLES=2, BASE_PORT=8'h10):
- Reset release -> an=8'hFF, seg=8'hFF, rd_data=0. Then digit 0 is on 2 cycles into slot 0: an=8'hFE, seg=8'hFF.
- Write 8'hC0 to 0x10, 8'hF9 to 0x11, MASK 0x18=8'h03 -> slot 0 shows an=FE/seg=C0 for 6 cycles, 2 blank cycles, slot 1 shows an=FD/seg=F9, slots 2..7 have an=FF. idx wraps 7->0 after 64 cycles.
- Read-back: port_id=0x11 -> rd_data=8'hF9 one cycle later. port_id=0x1A during slot 3 -> 8'h03. port_id=0x1F or 0x20 -> 8'h00.
- CTRL=8'h02 -> every slot in ON drives its anode low with seg=8'h00, MASK ignored. CTRL=8'h03 -> an=FF, seg=FF.
- Write DIGIT[0]=8'h92 mid-ON of slot 0 -> seg changes C0->92 exactly 2 clk after the strobe edge, with no anode change.
- Assert reset_n low mid-slot 5 -> an/seg go to FF immediately (async). After release, scanning restarts at idx 0 with a 2-cycle blank, and all registers are back at reset values.

Source files
------------

// File: rtl/display_scan_ctrl_pkg.sv
// Shared definitions for the seven-segment scan controller: register offsets,
// control bit positions, scan states and reset values.
package display_scan_ctrl_pkg;

    localparam int IDX_W = 3;

    localparam logic [3:0] OFF_MASK   = 4'd8;
    localparam logic [3:0] OFF_CTRL   = 4'd9;
    localparam logic [3:0] OFF_STATUS = 4'd10;

    localparam int CTRL_BLANK_ALL = 0;
    localparam int CTRL_LAMP_TEST = 1;

    typedef enum logic {
        ST_BLANK = 1'b0,
        ST_ON    = 1'b1
    } scan_state_t;

    localparam logic [7:0] DIGIT_RST = 8'hFF;
    localparam logic [7:0] MASK_RST  = 8'h01;
    localparam logic [1:0] CTRL_RST  = 2'b00;
    localparam logic [7:0] RD_RST    = 8'h00;
    localparam logic [7:0] SEG_OFF   = 8'hFF;
    localparam logic [7:0] SEG_LAMP  = 8'h00;

    function automatic logic [7:0] status_byte(input logic [IDX_W-1:0] idx);
        return {5'b0, idx};
    endfunction

endpackage

// File: rtl/display_scan_ctrl_scan_timer.sv
// Slot timer for the display scan: cycle counter, digit index and the
// BLANK/ON state machine. Exposes next-state values so outputs can be registered.
module display_scan_ctrl_scan_timer
    import display_scan_ctrl_pkg::*;
#(
    parameter int NUM_DIGITS   = 8,
    parameter int REFRESH_DIV  = 100000,
    parameter int BLANK_CYCLES = 1000
) (
    input  logic             clk,
    input  logic             reset_n,
    output logic [IDX_W-1:0] idx,
    output logic [IDX_W-1:0] idx_next,
    output scan_state_t      state_next
);

    localparam int CNT_W = $clog2(REFRESH_DIV);
    localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(REFRESH_DIV - 1);
    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'((BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0);
    localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NUM_DIGITS - 1);
    localparam scan_state_t      STATE_RST  = (BLANK_CYCLES > 0) ? ST_BLANK : ST_ON;

    logic [CNT_W-1:0] cnt_reg;
    logic [CNT_W-1:0] cnt_next;
    logic [IDX_W-1:0] idx_reg;
    scan_state_t      state_reg;
    logic             slot_last;
    logic             blank_last;

    assign slot_last  = (cnt_reg == CNT_LAST);
    assign blank_last = (cnt_reg == BLANK_LAST);
    assign idx        = idx_reg;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_reg   <= '0;
            idx_reg   <= '0;
            state_reg <= STATE_RST;
        end else begin
            cnt_reg   <= cnt_next;
            idx_reg   <= idx_next;
            state_reg <= state_next;
        end
    end

    always_comb begin
        cnt_next   = slot_last ? '0 : cnt_reg + CNT_W'(1);
        idx_next   = idx_reg;
        state_next = state_reg;
        if (slot_last) begin
            idx_next = (idx_reg == IDX_LAST) ? '0 : idx_reg + IDX_W'(1);
        end
        case (state_reg)
            ST_BLANK: if (blank_last) state_next = ST_ON;
            // Without a blank interval the machine simply never leaves ON.
            ST_ON:    if (slot_last && (BLANK_CYCLES > 0)) state_next = ST_BLANK;
            default:  state_next = STATE_RST;
        endcase
    end

endmodule

// File: rtl/display_scan_ctrl.sv
// PicoBlaze-attached 7-segment scan controller: digit/mask/control registers,
// registered read-back, and registered anode/segment drive.
module display_scan_ctrl
    import display_scan_ctrl_pkg::*;
#(
    parameter int         NUM_DIGITS   = 8,
    parameter int         REFRESH_DIV  = 100000,
    parameter int         BLANK_CYCLES = 1000,
    parameter logic [7:0] BASE_PORT    = 8'h10
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [7:0]            port_id,
    input  logic                  write_strobe,
    input  logic [7:0]            out_port,
    output logic [7:0]            rd_data,
    output logic [NUM_DIGITS-1:0] an,
    output logic [7:0]            seg
);

    logic [7:0]            digit_reg [NUM_DIGITS];
    logic [7:0]            mask_reg;
    logic [1:0]            ctrl_reg;
    logic [7:0]            rd_reg;
    logic [7:0]            rd_next;
    logic [NUM_DIGITS-1:0] an_reg;
    logic [NUM_DIGITS-1:0] an_next;
    logic [7:0]            seg_reg;
    logic [7:0]            seg_next;

    logic                  base_hit;
    logic [3:0]            offset;
    logic                  wr_en;
    logic [NUM_DIGITS-1:0] digit_hit;
    logic [NUM_DIGITS-1:0] idx_onehot;
    logic [7:0]            digit_cur;

    logic [IDX_W-1:0]      idx;
    logic [IDX_W-1:0]      idx_next;
    scan_state_t           state_next;

    display_scan_ctrl_scan_timer #(
        .NUM_DIGITS  (NUM_DIGITS),
        .REFRESH_DIV (REFRESH_DIV),
        .BLANK_CYCLES(BLANK_CYCLES)
    ) u_scan_timer (
        .clk       (clk),
        .reset_n   (reset_n),
        .idx       (idx),
        .idx_next  (idx_next),
        .state_next(state_next)
    );

    assign base_hit = (port_id[7:4] == BASE_PORT[7:4]);
    assign offset   = port_id[3:0];
    assign wr_en    = write_strobe && base_hit;

    // Offsets at or beyond NUM_DIGITS never match a digit, so they fall through as unmapped.
    generate
        for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_decode
            assign digit_hit[gi]  = (offset == 4'(gi));
            assign idx_onehot[gi] = (idx_next == IDX_W'(gi));
        end
    endgenerate

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
                digit_reg[i] <= DIGIT_RST;
            end
            mask_reg <= MASK_RST;
            ctrl_reg <= CTRL_RST;
        end else if (wr_en) begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
                if (digit_hit[i]) digit_reg[i] <= out_port;
            end
            if (offset == OFF_MASK) mask_reg <= out_port;
            if (offset == OFF_CTRL) ctrl_reg <= out_port[1:0];
        end
    end

    always_comb begin
        rd_next = RD_RST;
        if (base_hit) begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
                if (digit_hit[i]) rd_next = digit_reg[i];
            end
            case (offset)
                OFF_MASK:   rd_next = mask_reg;
                OFF_CTRL:   rd_next = {6'b0, ctrl_reg};
                OFF_STATUS: rd_next = status_byte(idx);
                default:    ;
            endcase
        end
    end

    always_comb begin
        digit_cur = SEG_OFF;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (idx_onehot[i]) digit_cur = digit_reg[i];
        end
    end

    // Drive is derived from the scan state being entered, so anodes and state change on the same edge.
    always_comb begin
        an_next  = '1;
        seg_next = SEG_OFF;
        if (!ctrl_reg[CTRL_BLANK_ALL] && (state_next == ST_ON)) begin
            if (ctrl_reg[CTRL_LAMP_TEST]) begin
                an_next  = ~idx_onehot;
                seg_next = SEG_LAMP;
            end else if (mask_reg[idx_next]) begin
                an_next  = ~idx_onehot;
                seg_next = digit_cur;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_reg  <= RD_RST;
            an_reg  <= '1;
            seg_reg <= SEG_OFF;
        end else begin
            rd_reg  <= rd_next;
            an_reg  <= an_next;
            seg_reg <= seg_next;
        end
    end

    assign rd_data = rd_reg;
    assign an      = an_reg;
    assign seg     = seg_reg;

endmodule
